serial_adder_seq: RTL and testbench



---
 rtl/serial_adder_seq_if.sv | 26 ++
 rtl/serial_adder_seq.sv | 78 +++++++
 tb/tb_serial_adder_seq.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_seq_if.sv
// Operand/result handshake bundle for serial_adder_seq.
// The master is the producer/consumer side; the slave is the adder.
interface serial_adder_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
endinterface

// File: rtl/serial_adder_seq.sv
// Bit-serial adder: one full-adder cell, LSB first, WIDTH cycles per operation.
// Result and carry registers drive sum/cout directly and hold until the next accept.
module serial_adder_seq #(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  serial_adder_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             accept;
  logic             s_bit, c_next;

  assign accept = (state_q == IDLE) && bus.in_valid;
  assign s_bit  = a_q[0] ^ b_q[0] ^ carry_q;
  assign c_next = (a_q[0] & b_q[0]) | (b_q[0] & carry_q) | (a_q[0] & carry_q);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b1;
    unique case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b0;
        if (bus.in_valid) state_d = SHIFT;
      end
      SHIFT: begin
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Counter saturates at LAST so it never wraps, even for power-of-two WIDTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else if (accept) begin
      a_q     <= bus.a;
      b_q     <= bus.b;
      res_q   <= '0;
      carry_q <= bus.cin;
      cnt_q   <= '0;
    end else if (state_q == SHIFT) begin
      a_q     <= {1'b0, a_q[WIDTH-1:1]};
      b_q     <= {1'b0, b_q[WIDTH-1:1]};
      res_q   <= {s_bit, res_q[WIDTH-1:1]};
      carry_q <= c_next;
      if (cnt_q != LAST) cnt_q <= cnt_q + CW'(1);
    end
  end

  assign bus.sum  = res_q;
  assign bus.cout = carry_q;
endmodule

// File: tb/tb_serial_adder_seq.sv
// Self-checking bench for serial_adder_seq (WIDTH=8) against a plain-arithmetic model.
module tb_serial_adder_seq;
  localparam int WIDTH = 8;
  localparam int LAT   = WIDTH;
  localparam int BOUND = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  serial_adder_seq_if #(.WIDTH(WIDTH)) bus ();

  serial_adder_seq #(.WIDTH(WIDTH)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: {cout, sum} is simply the (WIDTH+1)-bit sum of the operands.
  function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic c);
    return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
  endfunction

  // Presents operands in IDLE and takes the accept edge.
  task automatic accept_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c);
    bus.in_valid = 1'b1;
    bus.a = x;
    bus.b = y;
    bus.cin = c;
    step();
    bus.in_valid = 1'b0;
  endtask

  // Waits for out_valid; returns edges counted since the accept edge.
  task automatic wait_done(output int n);
    n = 0;
    while (!bus.out_valid && n < BOUND) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.sum !== '0 || bus.cout !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: in_ready=%b out_valid=%b busy=%b sum=%h cout=%b, want 1 0 0 00 0",
               bus.in_ready, bus.out_valid, bus.busy, bus.sum, bus.cout);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_directed();
    logic [WIDTH-1:0] ta[3] = '{8'h5A, 8'hFF, 8'hFF};
    logic [WIDTH-1:0] tb[3] = '{8'h3C, 8'h01, 8'hFF};
    logic             tc[3] = '{1'b0, 1'b0, 1'b1};
    logic [WIDTH:0]   exp;
    int n;
    for (int i = 0; i < 3; i++) begin
      exp = ref_add(ta[i], tb[i], tc[i]);
      accept_op(ta[i], tb[i], tc[i]);
      wait_done(n);
      vectors++;
      if (n !== LAT) begin
        miscompares++;
        $display("FAIL directed_latency[%0d]: got %0d edges, want %0d", i, n, LAT);
      end
      vectors++;
      if ({bus.cout, bus.sum} !== exp) begin
        miscompares++;
        $display("FAIL directed_result[%0d]: cout/sum=%b/%h want %b/%h", i, bus.cout, bus.sum,
                 exp[WIDTH], exp[WIDTH-1:0]);
      end
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      vectors++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
        miscompares++;
        $display("FAIL directed_idle[%0d]: in_ready=%b out_valid=%b busy=%b want 1 0 0", i,
                 bus.in_ready, bus.out_valid, bus.busy);
      end
    end
  endtask

  task automatic test_stall();
    logic [WIDTH-1:0] x, y;
    logic c;
    logic [WIDTH:0] exp;
    int n;
    x = WIDTH'($urandom);
    y = WIDTH'($urandom);
    c = 1'($urandom);
    exp = ref_add(x, y, c);
    accept_op(x, y, c);
    wait_done(n);
    for (int k = 0; k < 5; k++) begin
      step();
      vectors++;
      if (bus.out_valid !== 1'b1 || {bus.cout, bus.sum} !== exp) begin
        miscompares++;
        $display("FAIL stall[%0d]: out_valid=%b cout/sum=%b/%h want 1 %b/%h", k, bus.out_valid,
                 bus.cout, bus.sum, exp[WIDTH], exp[WIDTH-1:0]);
      end
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_release: in_ready=%b busy=%b out_valid=%b want 1 0 0", bus.in_ready,
               bus.busy, bus.out_valid);
    end
    step();
    step();
    vectors++;
    if ({bus.cout, bus.sum} !== exp) begin
      miscompares++;
      $display("FAIL retain: cout/sum=%b/%h want %b/%h", bus.cout, bus.sum, exp[WIDTH],
               exp[WIDTH-1:0]);
    end
  endtask

  task automatic test_ignore_inputs();
    logic [WIDTH:0] exp;
    int n;
    exp = ref_add(8'hC3, 8'h7E, 1'b1);
    accept_op(8'hC3, 8'h7E, 1'b1);
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.out_valid && n < BOUND) begin
      bus.a = WIDTH'($urandom);
      bus.b = WIDTH'($urandom);
      bus.cin = 1'($urandom);
      vectors++;
      if (bus.in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL ignore_ready[%0d]: in_ready=%b want 0", n, bus.in_ready);
      end
      step();
      n++;
    end
    bus.in_valid = 1'b0;
    vectors++;
    if (n !== LAT || {bus.cout, bus.sum} !== exp) begin
      miscompares++;
      $display("FAIL ignore_result: edges=%0d cout/sum=%b/%h want %0d %b/%h", n, bus.cout,
               bus.sum, LAT, exp[WIDTH], exp[WIDTH-1:0]);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [WIDTH:0] exp;
    int n;
    accept_op(8'hA5, 8'h5B, 1'b0);
    for (int k = 0; k < 4; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.sum !== '0 ||
        bus.in_ready !== 1'b1 || bus.cout !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: busy=%b out_valid=%b sum=%h cout=%b in_ready=%b want 0 0 00 0 1",
               bus.busy, bus.out_valid, bus.sum, bus.cout, bus.in_ready);
    end
    n = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (bus.out_valid) n++;
    end
    vectors++;
    if (n !== 0) begin
      miscompares++;
      $display("FAIL reset_mid_pulse: %0d out_valid cycles, want 0", n);
    end
    exp = ref_add(8'h81, 8'h92, 1'b1);
    accept_op(8'h81, 8'h92, 1'b1);
    wait_done(n);
    vectors++;
    if (n !== LAT || {bus.cout, bus.sum} !== exp) begin
      miscompares++;
      $display("FAIL reset_mid_recover: edges=%0d cout/sum=%b/%h want %0d %b/%h", n, bus.cout,
               bus.sum, LAT, exp[WIDTH], exp[WIDTH-1:0]);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] x, y;
    logic c;
    logic [WIDTH:0] exp;
    int n, t_acc, t_prev;
    bus.out_ready = 1'b1;
    x = WIDTH'($urandom);
    y = WIDTH'($urandom);
    c = 1'($urandom);
    bus.in_valid = 1'b1;
    bus.a = x;
    bus.b = y;
    bus.cin = c;
    t_prev = 0;
    for (int i = 0; i < 1000; i++) begin
      exp = ref_add(x, y, c);
      step();
      t_acc = cyc;
      bus.a = ~x;
      bus.b = ~y;
      wait_done(n);
      vectors++;
      if (n !== LAT || {bus.cout, bus.sum} !== exp) begin
        miscompares++;
        $display("FAIL b2b[%0d]: edges=%0d cout/sum=%b/%h want %0d %b/%h", i, n, bus.cout,
                 bus.sum, LAT, exp[WIDTH], exp[WIDTH-1:0]);
      end
      if (i > 0) begin
        vectors++;
        if (t_acc - t_prev !== WIDTH + 2) begin
          miscompares++;
          $display("FAIL b2b_spacing[%0d]: got %0d cycles, want %0d", i, t_acc - t_prev,
                   WIDTH + 2);
        end
      end
      t_prev = t_acc;
      x = WIDTH'($urandom);
      y = WIDTH'($urandom);
      c = 1'($urandom);
      bus.a = x;
      bus.b = y;
      bus.cin = c;
      if (i == 999) bus.in_valid = 1'b0;
      step();
    end
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    test_reset();
    test_directed();
    test_stall();
    test_ignore_inputs();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
